// File: rtl/rr_mux2_pkg.sv
// Shared types for the two-input round-robin stream multiplexer.
// Source index enum and the priority pointer reset value.
package rr_mux2_pkg;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_t;

  localparam src_t PTR_RESET = SRC0;

endpackage

// File: rtl/rr_mux2_stream_mux.sv
// Single-bit 2:1 multiplexer; the stream datapath instantiates one per data bit.
module mux (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/rr_mux2_stream.sv
// Two-input round-robin stream mux with a single-entry registered output stage.
// Grant counters are built only when RR_MUX2_STATS_EN is defined; otherwise cnt0/cnt1 read 0.
module rr_mux2_stream
  import rr_mux2_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [W-1:0]     in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [W-1:0]     in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output src_t             out_src,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  src_t         ptr;
  src_t         sel;
  logic         reg_free;
  logic         grant_any;
  logic         sel_bit;
  logic [W-1:0] mux_data;

  assign reg_free = !out_valid || out_ready;

  always_comb begin
    grant_any = 1'b0;
    sel       = ptr;
    if (reg_free && !rst) begin
      if (in0_valid && in1_valid) begin
        grant_any = 1'b1;
        sel       = ptr;
      end else if (in0_valid) begin
        grant_any = 1'b1;
        sel       = SRC0;
      end else if (in1_valid) begin
        grant_any = 1'b1;
        sel       = SRC1;
      end
    end
  end

  assign in0_ready = grant_any && (sel == SRC0);
  assign in1_ready = grant_any && (sel == SRC1);
  assign sel_bit   = (sel == SRC1);

  for (genvar i = 0; i < W; i++) begin : g_mux
    mux u_mux (
      .sel (sel_bit),
      .d0  (in0_data[i]),
      .d1  (in1_data[i]),
      .y   (mux_data[i])
    );
  end

  // A granted beat always transfers, since the grantee is valid and sees ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC0;
      ptr       <= PTR_RESET;
    end else if (grant_any) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_src   <= sel;
      ptr       <= (sel == SRC0) ? SRC1 : SRC0;
    end else if (reg_free) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX2_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (grant_any) begin
      if (sel == SRC0) cnt0_q <= cnt0_q + CNT_W'(1);
      else             cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_rr_mux2_stream.sv
// Self-checking bench for rr_mux2_stream: directed scenarios plus a randomized run
// against a transaction-level reference model. Works with or without RR_MUX2_STATS_EN.
module tb_rr_mux2_stream;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in1_valid, in0_ready, in1_ready;
  logic [W-1:0]     in0_data, in1_data, out_data;
  logic             out_valid, out_ready, out_src;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  rr_mux2_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  // Expected counter value after n grants to one source.
  function automatic int exp_cnt(int n);
`ifdef RR_MUX2_STATS_EN
    return n % (1 << CNT_W);
`else
    return 0;
`endif
  endfunction

  // Leaves the bench two time units after a falling edge with state cleared.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    in0_data = 8'h12; in1_data = 8'h34;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    n_tests++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL reset_out_src got %0b want 0", out_src); end
    n_tests++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
    n_tests++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b/%0b want 0/0", in0_ready, in1_ready); end
    @(negedge clk);
    rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %0b want 0", out_valid); end
    n_tests++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin n_fail++; $display("FAIL post_reset_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
  endtask

  task automatic test_single();
    logic [W-1:0] beat;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat = W'((i + 1) * 'h11);
      in0_valid = 1'b1; in0_data = beat;
      #1;
      n_tests++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready beat %0d got %0b want 1", i, in0_ready); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1 || out_data !== beat || out_src !== 1'b0)
        begin n_fail++; $display("FAIL single_out beat %0d got v=%0b d=%0h s=%0b want v=1 d=%0h s=0", i, out_valid, out_data, out_src, beat); end
      @(negedge clk);
    end
    in0_valid = 1'b0;
    n_tests++; if (int'(cnt0) !== exp_cnt(3)) begin n_fail++; $display("FAIL single_cnt0 got %0d want %0d", cnt0, exp_cnt(3)); end
  endtask

  task automatic test_contention();
    int exp_src;
    logic [W-1:0] exp_d;
    do_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in0_data = W'('hA0 + (i + 1) / 2);
      in1_data = W'('hB0 + i / 2);
      exp_src = i % 2;
      exp_d   = (exp_src == 0) ? W'('hA0 + i / 2) : W'('hB0 + i / 2);
      #1;
      n_tests++; if (in0_ready !== (exp_src == 0) || in1_ready !== (exp_src == 1))
        begin n_fail++; $display("FAIL contention_ready beat %0d got %0b/%0b want src %0d", i, in0_ready, in1_ready, exp_src); end
      @(posedge clk); #1;
      n_tests++; if (int'(out_src) !== exp_src || out_data !== exp_d)
        begin n_fail++; $display("FAIL contention_out beat %0d got s=%0b d=%0h want s=%0d d=%0h", i, out_src, out_data, exp_src, exp_d); end
      @(negedge clk);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_tests++; if (int'(cnt0) !== exp_cnt(4) || int'(cnt1) !== exp_cnt(4))
      begin n_fail++; $display("FAIL contention_cnt got %0d/%0d want %0d/%0d", cnt0, cnt1, exp_cnt(4), exp_cnt(4)); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    in0_valid = 1'b1; in0_data = 8'h5A;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin n_fail++; $display("FAIL bp_load got v=%0b d=%0h want v=1 d=5a", out_valid, out_data); end
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d got %0b/%0b want 0/0", i, in0_ready, in1_ready); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold cycle %0d got v=%0b d=%0h s=%0b want v=1 d=5a s=0", i, out_valid, out_data, out_src); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_drain_ready got %0b/%0b want 0/1", in0_ready, in1_ready); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_src !== 1'b1)
      begin n_fail++; $display("FAIL bp_swap got v=%0b d=%0h s=%0b want v=1 d=3c s=1", out_valid, out_data, out_src); end
    @(negedge clk);
    in1_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b want 0", out_valid); end
    n_tests++; if (int'(cnt0) !== exp_cnt(1) || int'(cnt1) !== exp_cnt(1))
      begin n_fail++; $display("FAIL bp_cnt got %0d/%0d want %0d/%0d", cnt0, cnt1, exp_cnt(1), exp_cnt(1)); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready = 1'b1; in1_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in1_data = W'($urandom);
      @(posedge clk); #1;
      if (i == 14) begin
        n_tests++; if (int'(cnt1) !== exp_cnt(15)) begin n_fail++; $display("FAIL wrap_allones got %0d want %0d", cnt1, exp_cnt(15)); end
      end
      @(negedge clk);
    end
    in1_valid = 1'b0;
    n_tests++; if (int'(cnt1) !== exp_cnt(17)) begin n_fail++; $display("FAIL wrap_cnt1 got %0d want %0d", cnt1, exp_cnt(17)); end
    n_tests++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt0 got %0d want 0", cnt0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'hA0; in1_data = 8'hB0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %0b want 0", out_valid); end
    n_tests++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready got %0b/%0b want 0/0", in0_ready, in1_ready); end
    #1 rst = 1'b0;
    #1;
    n_tests++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL async_first_ready got %0b/%0b want 1/0", in0_ready, in1_ready); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'hA0)
      begin n_fail++; $display("FAIL async_first_grant got v=%0b s=%0b d=%0h want v=1 s=0 d=a0", out_valid, out_src, out_data); end
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  // Reference model: a one-slot buffer fed by a fair two-way arbiter whose
  // preference flips to the other source after every accepted beat.
  task automatic test_random();
    bit           m_valid = 0;
    int           m_src = 0, pref = 0, g;
    logic [W-1:0] m_data = '0;
    int           m_cnt [2] = '{0, 0};
    bit           free;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!in0_valid && ($urandom % 3 != 0)) begin in0_valid = 1'b1; in0_data = W'($urandom); end
      if (!in1_valid && ($urandom % 3 != 0)) begin in1_valid = 1'b1; in1_data = W'($urandom); end
      out_ready = ($urandom % 4 != 0);
      #1;
      free = !m_valid || out_ready;
      if (!free)                       g = -1;
      else if (in0_valid && in1_valid) g = pref;
      else if (in0_valid)              g = 0;
      else if (in1_valid)              g = 1;
      else                             g = -1;
      n_tests++; if (in0_ready !== (g == 0) || in1_ready !== (g == 1))
        begin n_fail++; $display("FAIL rand_ready cycle %0d got %0b/%0b want grant %0d", c, in0_ready, in1_ready, g); end
      @(posedge clk);
      if (g >= 0) begin
        m_valid = 1; m_src = g; m_data = (g == 0) ? in0_data : in1_data;
        pref = 1 - g; m_cnt[g]++;
      end else if (free) begin
        m_valid = 0;
      end
      #1;
      n_tests++; if (out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_src) !== m_src)))
        begin n_fail++; $display("FAIL rand_out cycle %0d got v=%0b d=%0h s=%0b want v=%0b d=%0h s=%0d", c, out_valid, out_data, out_src, m_valid, m_data, m_src); end
      n_tests++; if (int'(cnt0) !== exp_cnt(m_cnt[0]) || int'(cnt1) !== exp_cnt(m_cnt[1]))
        begin n_fail++; $display("FAIL rand_cnt cycle %0d got %0d/%0d want %0d/%0d", c, cnt0, cnt1, exp_cnt(m_cnt[0]), exp_cnt(m_cnt[1])); end
      @(negedge clk);
      if (g == 0) in0_valid = 1'b0;
      if (g == 1) in1_valid = 1'b0;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_counter_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1, "timeout");
  end

endmodule
